// File: rtl/lfsr8_checker.sv
// lfsr8_checker: self-synchronising checker for an 8-bit Fibonacci LFSR stream
// (taps 7,5,4,3). It fills a history, locks after a run of correct predictions,
// then free-runs its own reference and counts mispredicted bits.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_FILL | loading the first 8 valid bits into the history, no checks
// S_SYNC | predicting and loading received bits, counting matches
// S_LOCK | free-running reference, counting and flagging mispredictions
module lfsr8_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 I_VALID,
  input  logic                 I,
  input  logic                 CLEAR,
  output logic                 LOCKED,
  output logic                 ERR_PULSE,
  output logic [ERR_WIDTH-1:0] ERR_COUNT
);

  typedef enum logic [1:0] {S_FILL, S_SYNC, S_LOCK} state_t;

  // Terminal values: the transition fires on the edge the counter would reach the limit.
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

  state_t               state, state_nxt;
  logic [7:0]           hist, hist_nxt;
  logic [2:0]           fill_cnt, fill_cnt_nxt;
  logic [7:0]           match_cnt, match_cnt_nxt;
  logic [7:0]           bad_cnt, bad_cnt_nxt;
  logic                 locked, locked_nxt;
  logic                 err_pulse, err_pulse_nxt;
  logic [ERR_WIDTH-1:0] err_count, err_count_nxt;
  logic                 pred;
  logic                 mismatch;

  assign pred     = hist[7] ^ hist[5] ^ hist[4] ^ hist[3];
  assign mismatch = I ^ pred;

  // State, history, counters and registered outputs; reset is asynchronous.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill_cnt  <= fill_cnt_nxt;
      match_cnt <= match_cnt_nxt;
      bad_cnt   <= bad_cnt_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_pulse_nxt;
      err_count <= err_count_nxt;
    end
  end

  // Next-state and counter logic; idle cycles hold everything and drop the pulse.
  always_comb begin
    state_nxt     = state;
    hist_nxt      = hist;
    fill_cnt_nxt  = fill_cnt;
    match_cnt_nxt = match_cnt;
    bad_cnt_nxt   = bad_cnt;
    locked_nxt    = locked;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_count;

    if (I_VALID) begin
      case (state)
        S_FILL: begin
          hist_nxt = {hist[6:0], I};
          if (fill_cnt == 3'd7) begin
            state_nxt     = S_SYNC;
            fill_cnt_nxt  = '0;
            match_cnt_nxt = '0;
          end else begin
            fill_cnt_nxt = fill_cnt + 3'd1;
          end
        end
        S_SYNC: begin
          // Received bits are loaded so a wrong history heals itself; an
          // all-zero history predicts zeros forever and must never count.
          hist_nxt = {hist[6:0], I};
          if (mismatch || (hist == 8'h00)) begin
            match_cnt_nxt = '0;
          end else if (match_cnt == LOCK_LAST) begin
            state_nxt     = S_LOCK;
            locked_nxt    = 1'b1;
            match_cnt_nxt = '0;
            bad_cnt_nxt   = '0;
          end else begin
            match_cnt_nxt = match_cnt + 8'd1;
          end
        end
        S_LOCK: begin
          // The prediction, not the received bit, feeds the history so a
          // single corrupted bit cannot echo into later predictions.
          hist_nxt = {hist[6:0], pred};
          if (mismatch) begin
            err_pulse_nxt = 1'b1;
            if (err_count != '1) err_count_nxt = err_count + 1'b1;
            if (bad_cnt == LOSS_LAST) begin
              state_nxt     = S_SYNC;
              locked_nxt    = 1'b0;
              match_cnt_nxt = '0;
              bad_cnt_nxt   = '0;
            end else begin
              bad_cnt_nxt = bad_cnt + 8'd1;
            end
          end else begin
            bad_cnt_nxt = '0;
          end
        end
        default: state_nxt = S_FILL;
      endcase
    end

    if (CLEAR) err_count_nxt = '0;
  end

  assign LOCKED    = locked;
  assign ERR_PULSE = err_pulse;
  assign ERR_COUNT = err_count;

endmodule

// File: tb/tb_lfsr8_checker.sv
// Directed bench for lfsr8_checker: a reference generator (taps 7,5,4,3,
// seed 0x01) drives the stream; a second instance with a 4-bit error counter
// shares all inputs to exercise saturation.
module tb_lfsr8_checker;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I_VALID = 1'b0;
  logic        I = 1'b0;
  logic        CLEAR = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] gen;

  lfsr8_checker dut (
    .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .I(I), .CLEAR(CLEAR),
    .LOCKED(locked), .ERR_PULSE(err_pulse), .ERR_COUNT(err_count)
  );

  lfsr8_checker #(.LOCK_COUNT(16), .LOSS_COUNT(4), .ERR_WIDTH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .I(I), .CLEAR(CLEAR),
    .LOCKED(locked4), .ERR_PULSE(err_pulse4), .ERR_COUNT(err_count4)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge CLK);
    I_VALID = v;
    I = b;
    CLEAR = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic next_gen(output logic b);
    b = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
    gen = {gen[6:0], b};
  endtask

  task automatic send_clean();
    logic b;
    next_gen(b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic send_bad(input logic c);
    logic b;
    next_gen(b);
    step(1'b1, ~b, c);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    I_VALID = 1'b0;
    I = 1'b0;
    CLEAR = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    gen = 8'h01;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b expected 0", err_pulse); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", err_count); end
  endtask

  // Lock must appear after the edge sampling valid bit 24 and not before.
  task automatic test_clean_lock();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      send_clean();
      n_cmp++;
      if (locked !== (k >= 24)) begin
        n_bad++; $display("FAIL clean_lock bit %0d: got %b expected %b", k, locked, (k >= 24));
      end
    end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clean_count: got %0d expected 0", err_count); end
  endtask

  task automatic test_single_error();
    send_bad(1'b0);
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL single_pulse_hi: got %b expected 1", err_pulse); end
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %b expected 1", locked); end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL idle_pulse: got %b expected 0", err_pulse); end
    for (int k = 0; k < 10; k++) begin
      send_clean();
      n_cmp++;
      if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL single_after %0d: pulse got %b expected 0", k, err_pulse); end
    end
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL single_count_after: got %0d expected 1", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked_after: got %b expected 1", locked); end
  endtask

  task automatic test_loss_relock();
    for (int k = 1; k <= 4; k++) begin
      send_bad(1'b0);
      n_cmp++;
      if (locked !== (k < 4)) begin n_bad++; $display("FAIL loss_locked bad %0d: got %b expected %b", k, locked, (k < 4)); end
      n_cmp++;
      if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL loss_pulse bad %0d: got %b expected 1", k, err_pulse); end
    end
    n_cmp++; if (err_count !== 16'd5) begin n_bad++; $display("FAIL loss_count: got %0d expected 5", err_count); end
    for (int k = 1; k <= 16; k++) begin
      send_clean();
      n_cmp++;
      if (locked !== (k >= 16)) begin n_bad++; $display("FAIL relock bit %0d: got %b expected %b", k, locked, (k >= 16)); end
    end
    n_cmp++; if (err_count !== 16'd5) begin n_bad++; $display("FAIL relock_count: got %0d expected 5", err_count); end
  endtask

  task automatic test_zero_stream();
    logic seen_lock;
    logic seen_err;
    seen_lock = 1'b0;
    seen_err = 1'b0;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (locked) seen_lock = 1'b1;
      if (err_count != 16'd0) seen_err = 1'b1;
    end
    n_cmp++; if (seen_lock !== 1'b0) begin n_bad++; $display("FAIL zero_locked: got %b expected 0", seen_lock); end
    n_cmp++; if (seen_err !== 1'b0) begin n_bad++; $display("FAIL zero_count: got %b expected 0", seen_err); end
  endtask

  // Idle cycles carry junk on I; they must not shift the lock point.
  task automatic test_gapped();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      send_clean();
      n_cmp++;
      if (locked !== (k >= 24)) begin n_bad++; $display("FAIL gap_lock bit %0d: got %b expected %b", k, locked, (k >= 24)); end
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (locked !== (k >= 24) || err_pulse !== 1'b0) begin
        n_bad++; $display("FAIL gap_idle bit %0d: locked %b pulse %b expected %b 0", k, locked, err_pulse, (k >= 24));
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 20; k++) begin
      send_bad(1'b0);
      send_clean();
      n_cmp++;
      if (err_count4 !== 4'((k > 15) ? 15 : k)) begin
        n_bad++; $display("FAIL sat4 err %0d: got %0d expected %0d", k, err_count4, (k > 15) ? 15 : k);
      end
    end
    n_cmp++; if (err_count !== 16'd20) begin n_bad++; $display("FAIL sat_wide: got %0d expected 20", err_count); end
    n_cmp++; if (locked !== 1'b1 || locked4 !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %b/%b expected 1/1", locked, locked4); end
  endtask

  task automatic test_clear_collision();
    send_bad(1'b1);
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL clear_count: got %0d expected 0", err_count); end
    n_cmp++; if (err_count4 !== 4'd0) begin n_bad++; $display("FAIL clear_count4: got %0d expected 0", err_count4); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL clear_pulse: got %b expected 1", err_pulse); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL clear_locked: got %b expected 1", locked); end
    send_clean();
    send_bad(1'b0);
    n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL clear_then_err: got %0d expected 1", err_count); end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    I_VALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL async_locked: got %b expected 0", locked); end
    n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL async_count: got %0d expected 0", err_count); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL async_pulse: got %b expected 0", err_pulse); end
    @(negedge CLK);
    RESET = 1'b0;
    gen = 8'h01;
    for (int k = 1; k <= 24; k++) begin
      send_clean();
      n_cmp++;
      if (locked !== (k >= 24)) begin n_bad++; $display("FAIL async_relock bit %0d: got %b expected %b", k, locked, (k >= 24)); end
    end
  endtask

  initial begin
    gen = 8'h01;
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_relock();
    test_zero_stream();
    test_gapped();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr8_checker.md
LFSR8_CHECKER -- requirements
Module: lfsr8_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 16: consecutive correct predictions required to declare lock (range 1..255).
REQ-002 The block SHALL have parameter LOSS_COUNT, default 4: consecutive mispredictions while locked that drop lock (range 1..255).
REQ-003 The block SHALL have parameter ERR_WIDTH, default 16: width of the error counter.
REQ-004 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port I_VALID, input, 1 bit: I carries a stream bit this cycle.
REQ-007 The block SHALL have port I, input, 1 bit: serial bit produced by the upstream 8-bit LFSR generator (its feedback bit, i.e. new O[0] each step).
REQ-008 The block SHALL have port CLEAR, input, 1 bit: synchronous clear of ERR_COUNT.
REQ-009 The block SHALL have port LOCKED, output, 1 bit: checker is synchronised to the stream.
REQ-010 The block SHALL have port ERR_PULSE, output, 1 bit: one-cycle flag for a mispredicted bit while locked.
REQ-011 The block SHALL have port ERR_COUNT, output, ERR_WIDTH bits: saturating count of locked-state mispredictions.

Function
REQ-012 The block SHALL hold an 8-bit history H, shifting left on each accepted bit (H <= {H[6:0], b}).
REQ-013 The predicted bit SHALL be P = H[7]^H[5]^H[4]^H[3], matching generator taps 7,5,4,3.
REQ-014 Cycles with I_VALID=0 SHALL leave all state and counters unchanged and hold ERR_PULSE at 0.
REQ-015 The FSM SHALL have three states: FILL, SYNC and LOCK.
REQ-016 In FILL, the block SHALL load I into H on each valid bit, with no comparison; after the 8th valid bit it SHALL move to SYNC with match_cnt=0.
REQ-017 In SYNC, the block SHALL compare I to P on each valid bit and SHALL load the received bit I into H (self-synchronising).
REQ-018 In SYNC, a match with H != 0 SHALL increment match_cnt.
REQ-019 In SYNC, a mismatch, or any bit received while H == 0, SHALL clear match_cnt; this all-zero lockup guard means a constant-zero stream never locks.
REQ-020 When match_cnt reaches LOCK_COUNT, the block SHALL enter LOCK and set LOCKED=1 on that same edge.
REQ-021 In LOCK, the block SHALL load the predicted bit P into H (free-running reference), so one corrupted bit yields exactly one error.
REQ-022 In LOCK, a mismatch SHALL set ERR_PULSE=1 for the following cycle, increment ERR_COUNT (saturating at all-ones) and increment bad_cnt.
REQ-023 In LOCK, a match SHALL clear bad_cnt.
REQ-024 When bad_cnt reaches LOSS_COUNT, the block SHALL enter SYNC, set LOCKED=0, clear match_cnt and bad_cnt, and count the triggering error.
REQ-025 All outputs SHALL be registered, with 1-cycle latency from the sampling edge.
REQ-026 If CLEAR and a counted error occur on the same edge, CLEAR SHALL take priority and ERR_COUNT SHALL become 0; ERR_PULSE SHALL still assert.
REQ-027 CLEAR SHALL NOT affect the FSM, H, LOCKED, or lock/loss counters.

Reset
REQ-028 RESET=1 SHALL asynchronously force state FILL and set H=0, fill counter=0, match_cnt=0 and bad_cnt=0.
REQ-029 RESET=1 SHALL asynchronously force LOCKED=0, ERR_PULSE=0 and ERR_COUNT=0.
REQ-030 RESET asserted mid-lock SHALL drop LOCKED immediately (not at the next edge); after release the checker SHALL restart from FILL.

Verification
REQ-031 Clean stream -- generator seeded 0x01 (first bits 0,0,0,1,...), I_VALID=1, defaults -> LOCKED=1 after the edge sampling valid bit 24 (8 fill + 16 matches); ERR_COUNT=0 throughout.
REQ-032 Single-bit error -- one bit inverted while locked -> ERR_PULSE high exactly one cycle, ERR_COUNT=1, LOCKED stays 1; the next bits produce no further errors.
REQ-033 Loss and relock -- 4 consecutive inverted bits while locked -> ERR_COUNT+=4, LOCKED=0 after the 4th; clean bits resumed -> LOCKED=1 after 16 further matches.
REQ-034 Zero stream -- I=0, I_VALID=1 for 200 cycles after reset -> LOCKED never asserts and ERR_COUNT stays 0.
REQ-035 Gapped input -- I_VALID toggling 1/0 with the clean stream -> lock is reached at the same valid-bit index as REQ-031; idle cycles change nothing.
REQ-036 Saturation and reset -- ERR_WIDTH=4 with 20 isolated errors -> ERR_COUNT=15; CLEAR together with an error -> 0; asynchronous RESET pulse mid-lock -> LOCKED=0 before the next edge.
